// File: rtl/alu_add_arbiter.sv
// rtl/alu_add_arbiter.sv - round-robin arbiter sharing one external combinational adder among NREQ requesters
module alu_add_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*WIDTH-1:0]      req_rs1,
    input  logic [NREQ*WIDTH-1:0]      req_rs2,
    output logic [WIDTH-1:0]           alu_rs1,
    output logic [WIDTH-1:0]           alu_rs2,
    input  logic [WIDTH-1:0]           alu_rd,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [WIDTH-1:0]           resp_rd,
    output logic [$clog2(NREQ)-1:0]    resp_id,
    output logic                       busy
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state, next_state;
    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   id_reg;
    logic [WIDTH-1:0] op1, op2;
    logic [IDW-1:0]   winner;
    logic             found;

    logic [WIDTH-1:0] rs1_arr [NREQ];
    logic [WIDTH-1:0] rs2_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign rs1_arr[gi] = req_rs1[gi*WIDTH +: WIDTH];
        assign rs2_arr[gi] = req_rs2[gi*WIDTH +: WIDTH];
    end

    // Search starts just past the previous winner so every requester waits at most NREQ-1 grants.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 1; k <= NREQ; k++) begin
            int             s;
            logic [IDW-1:0] cand;
            s    = (int'(last_grant) + k) % NREQ;
            cand = IDW'(s);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        req_ready  = '0;
        case (state)
            IDLE: begin
                if (found && !rst) begin
                    req_ready[winner] = 1'b1;
                    next_state        = EXEC;
                end
            end
            EXEC:    next_state = RESP;
            RESP:    if (resp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= IDW'(NREQ - 1);
            id_reg     <= '0;
            op1        <= '0;
            op2        <= '0;
            resp_valid <= 1'b0;
            resp_rd    <= '0;
            resp_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        op1        <= rs1_arr[winner];
                        op2        <= rs2_arr[winner];
                        id_reg     <= winner;
                        last_grant <= winner;
                    end
                end
                EXEC: begin
                    resp_rd    <= alu_rd;
                    resp_id    <= id_reg;
                    resp_valid <= 1'b1;
                end
                RESP: begin
                    if (resp_ready) resp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Adder operands come only from registers, isolating the shared adder from request-side timing.
    assign alu_rs1 = op1;
    assign alu_rs2 = op2;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_alu_add_arbiter.sv
// tb/tb_alu_add_arbiter.sv - self-checking bench for alu_add_arbiter
module tb_alu_add_arbiter;
    localparam int W = 32;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_rs1, req_rs2;
    logic [W-1:0]   alu_rs1, alu_rs2, alu_rd;
    logic           resp_valid, resp_ready;
    logic [W-1:0]   resp_rd;
    logic [1:0]     resp_id;
    logic           busy;

    logic [W-1:0]   a_tb [N];
    logic [W-1:0]   b_tb [N];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign req_rs1[gi*W +: W] = a_tb[gi];
        assign req_rs2[gi*W +: W] = b_tb[gi];
    end

    // External shared adder.
    assign alu_rd = alu_rs1 + alu_rs2;

    alu_add_arbiter #(.WIDTH(W), .NREQ(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2),
        .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_rd(alu_rd),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rd(resp_rd), .resp_id(resp_id), .busy(busy)
    );

    typedef struct packed {
        logic [W-1:0] rd;
        logic [1:0]   id;
    } exp_t;

    typedef struct {
        int           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] rd;
    } vec_t;

    exp_t sb [$];
    int   glog_id [$];
    int   glog_cyc [$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: expected sum pushed at request handshake, popped at response handshake.
    always @(negedge clk) begin
        if (!rst) begin
            chk("req_ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb.push_back('{rd: a_tb[i] + b_tb[i], id: 2'(i)});
                    glog_id.push_back(i);
                    glog_cyc.push_back(cyc);
                end
            end
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected_resp: got id %0d rd %0h expected none", resp_id, resp_rd);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_rd", 64'(resp_rd), 64'(e.rd));
                    chk("sb_id", 64'(resp_id), 64'(e.id));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        req_valid = '0;
        tick();
        sb.delete();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_resp();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 12 && !ok; c++) begin
            @(negedge clk);
            #1;
            if (resp_valid) ok = 1'b1;
        end
        if (!ok) chk("resp_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            #1;
            if (!busy) ok = 1'b1;
        end
        if (!ok) chk("idle_timeout", 64'd0, 64'd1);
        tick();
    endtask

    task automatic do_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] rd, output logic [1:0] rid);
        bit ok;
        ok = 1'b0;
        a_tb[id] = a;
        b_tb[id] = b;
        req_valid[id] = 1'b1;
        for (int c = 0; c < 12 && !ok; c++) begin
            @(negedge clk);
            #1;
            if (req_ready[id]) ok = 1'b1;
            tick();
        end
        if (!ok) chk("grant_timeout_op", 64'd0, 64'd1);
        req_valid[id] = 1'b0;
        wait_resp();
        rd  = resp_rd;
        rid = resp_id;
        tick();
    endtask

    task automatic run_grants(input int n, input bit drop);
        bit           done;
        logic [N-1:0] g;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            #1;
            g = req_valid & req_ready;
            if (glog_id.size() >= n) done = 1'b1;
            tick();
            if (drop) req_valid = req_valid & ~g;
        end
        if (!done) chk("grant_timeout", 64'd0, 64'd1);
        req_valid = '0;
    endtask

    initial begin
        vec_t         vecs [6];
        logic [W-1:0] rd;
        logic [1:0]   rid;

        vecs[0] = '{id: 0, a: 32'd1,          b: 32'd1,          rd: 32'd2};
        vecs[1] = '{id: 1, a: 32'hFFFF_FFFF,  b: 32'd2,          rd: 32'h0000_0001};
        vecs[2] = '{id: 2, a: -32'sd1661027666, b: 32'd2067214708, rd: 32'd406187042};
        vecs[3] = '{id: 3, a: 32'h8000_0000,  b: 32'h8000_0000,  rd: 32'h0};
        vecs[4] = '{id: 0, a: 32'h7FFF_FFFF,  b: 32'd1,          rd: 32'h8000_0000};
        vecs[5] = '{id: 3, a: 32'h1234_5678,  b: 32'h1111_1111,  rd: 32'h2345_6789};

        rst = 1'b1;
        req_valid = '0;
        resp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            a_tb[i] = '0;
            b_tb[i] = '0;
        end
        tick();
        tick();
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_rd", 64'(resp_rd), 64'd0);
        chk("rst_resp_id", 64'(resp_id), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_alu_rs1", 64'(alu_rs1), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Cycle-exact latency of a single op from requester 0.
        a_tb[0] = 32'd1;
        b_tb[0] = 32'd1;
        req_valid = 4'b0001;
        @(negedge clk);
        chk("t1_ready_T", 64'(req_ready), 64'h1);
        chk("t1_busy_T", 64'(busy), 64'd0);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("t1_busy_T1", 64'(busy), 64'd1);
        chk("t1_valid_T1", 64'(resp_valid), 64'd0);
        chk("t1_ready_T1", 64'(req_ready), 64'd0);
        chk("t1_alu_rs1", 64'(alu_rs1), 64'd1);
        tick();
        @(negedge clk);
        chk("t1_valid_T2", 64'(resp_valid), 64'd1);
        chk("t1_rd", 64'(resp_rd), 64'd2);
        chk("t1_id", 64'(resp_id), 64'd0);
        chk("t1_busy_T2", 64'(busy), 64'd1);
        tick();
        @(negedge clk);
        chk("t1_busy_T3", 64'(busy), 64'd0);
        chk("t1_valid_T3", 64'(resp_valid), 64'd0);
        tick();

        for (int v = 0; v < 6; v++) begin
            do_op(vecs[v].id, vecs[v].a, vecs[v].b, rd, rid);
            chk($sformatf("vec%0d_rd", v), 64'(rd), 64'(vecs[v].rd));
            chk($sformatf("vec%0d_id", v), 64'(rid), 64'(vecs[v].id));
        end

        // All four held valid: rotation 0,1,2,3,0 spaced three cycles apart.
        reset_pulse();
        for (int i = 0; i < N; i++) begin
            a_tb[i] = $urandom;
            b_tb[i] = $urandom;
        end
        a_tb[2] = -32'sd1661027666;
        b_tb[2] = 32'd2067214708;
        glog_id.delete();
        glog_cyc.delete();
        req_valid = 4'b1111;
        run_grants(5, 1'b0);
        wait_idle();
        chk("t3_ngrants", 64'(glog_id.size()), 64'd5);
        for (int k = 0; k < 5 && k < glog_id.size(); k++) begin
            chk($sformatf("t3_order%0d", k), 64'(glog_id[k]), 64'(k % N));
            if (k > 0) chk($sformatf("t3_gap%0d", k), 64'(glog_cyc[k] - glog_cyc[k-1]), 64'd3);
        end

        // Back-pressure on the response port.
        resp_ready = 1'b0;
        a_tb[1] = 32'hDEAD_0000;
        b_tb[1] = 32'h0000_BEEF;
        req_valid = 4'b0010;
        run_grants(glog_id.size() + 1, 1'b1);
        a_tb[2] = 32'd7;
        b_tb[2] = 32'd8;
        req_valid = 4'b0100;
        wait_resp();
        for (int c = 0; c < 5; c++) begin
            tick();
            @(negedge clk);
            chk("t4_hold_valid", 64'(resp_valid), 64'd1);
            chk("t4_hold_rd", 64'(resp_rd), 64'hDEAD_BEEF);
            chk("t4_hold_id", 64'(resp_id), 64'd1);
            chk("t4_hold_ready", 64'(req_ready), 64'd0);
            chk("t4_hold_busy", 64'(busy), 64'd1);
        end
        tick();
        resp_ready = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("t4_idle_busy", 64'(busy), 64'd0);
        chk("t4_idle_valid", 64'(resp_valid), 64'd0);
        chk("t4_idle_ready", 64'(req_ready), 64'h4);
        tick();
        req_valid = '0;
        wait_idle();

        // After a grant to 2, requester 3 outranks requester 1.
        reset_pulse();
        do_op(2, 32'd10, 32'd20, rd, rid);
        chk("t5_pre_rd", 64'(rd), 64'd30);
        glog_id.delete();
        glog_cyc.delete();
        a_tb[1] = 32'd100;
        b_tb[1] = 32'd1;
        a_tb[3] = 32'd300;
        b_tb[3] = 32'd3;
        req_valid = 4'b1010;
        run_grants(2, 1'b1);
        wait_idle();
        chk("t5_n", 64'(glog_id.size()), 64'd2);
        if (glog_id.size() >= 2) begin
            chk("t5_first", 64'(glog_id[0]), 64'd3);
            chk("t5_second", 64'(glog_id[1]), 64'd1);
        end

        // Reset while an op is in EXEC: nothing returned, requester 0 regains priority.
        a_tb[0] = 32'd5;
        b_tb[0] = 32'd6;
        req_valid = 4'b0001;
        @(negedge clk);
        chk("t6_grant", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_valid", 64'(resp_valid), 64'd0);
        sb.delete();
        tick();
        @(negedge clk);
        chk("t6_rst_valid2", 64'(resp_valid), 64'd0);
        tick();
        rst = 1'b0;
        glog_id.delete();
        glog_cyc.delete();
        a_tb[2] = 32'd40;
        b_tb[2] = 32'd2;
        req_valid = 4'b0101;
        run_grants(2, 1'b1);
        wait_idle();
        chk("t6_n", 64'(glog_id.size()), 64'd2);
        if (glog_id.size() >= 2) begin
            chk("t6_first", 64'(glog_id[0]), 64'd0);
            chk("t6_second", 64'(glog_id[1]), 64'd2);
        end

        tick();
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
